// File: rtl/ef_smsdac_mon_pkg.sv
// Shared types and constants for the segmented mismatch-shaping DAC loopback monitor.
// Holds the FSM state encoding, element code constants and the element decode helper.
package ef_smsdac_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam logic [1:0] EL_POS  = 2'b10;
    localparam logic [1:0] EL_NEG  = 2'b01;
    localparam logic [1:0] EL_ZERO = 2'b00;
    localparam logic [1:0] EL_ILL  = 2'b11;

    localparam logic signed [8:0] REF_OFFSET = 9'sd128;

    // {p,n} -> p - n; the illegal code 2'b11 contributes nothing.
    function automatic logic signed [4:0] el_val(input logic [1:0] code);
        case (code)
            EL_POS:  return 5'sd1;
            EL_NEG:  return -5'sd1;
            default: return 5'sd0;
        endcase
    endfunction

endpackage

// File: rtl/ef_smsdac_mon_boxcar.sv
// Signed boxcar accumulator: sum = running total including the current input (combinational).
// Dump reloads the accumulator with zero on the same edge; clr zeroes it. No backpressure.
module ef_smsdac_mon_boxcar #(
    parameter int W_IN     = 5,
    parameter int LOG2_DEC = 6
) (
    input  logic                             clk,
    input  logic                             rst_b,
    input  logic                             clr,
    input  logic                             acc_en,
    input  logic                             dump,
    input  logic signed [W_IN-1:0]           din,
    output logic signed [W_IN+LOG2_DEC-1:0]  sum
);

    localparam int W_OUT = W_IN + LOG2_DEC;

    logic signed [W_OUT-1:0] acc_q, acc_d;
    logic signed [W_OUT-1:0] din_ext;

    assign din_ext = {{LOG2_DEC{din[W_IN-1]}}, din};
    assign sum     = acc_q + din_ext;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = dump ? '0 : sum;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/ef_smsdac_mon.sv
// Loopback monitor: decodes the 4 element codes, boxcar-decimates them against the delayed input word.
// Window totals appear one cycle after the last sample of the window; no backpressure (free-running).
module ef_smsdac_mon
    import ef_smsdac_mon_pkg::*;
#(
    parameter int LOG2_DEC = 6,
    parameter int LAT      = 2,
    parameter int SHIFT    = 3,
    parameter int TOL      = 256
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      en,
    input  logic                      clr,
    input  logic [7:0]                d_in,
    input  logic [1:0]                d_el_3,
    input  logic [1:0]                d_el_2,
    input  logic [1:0]                d_el_1,
    input  logic [1:0]                d_el_0,
    output logic signed [4+LOG2_DEC:0] dec_out,
    output logic signed [8+LOG2_DEC:0] ref_out,
    output logic                      dec_valid,
    output logic                      err_flag,
    output logic [7:0]                err_cnt,
    output logic                      busy
);

    localparam int W_DEC = 5 + LOG2_DEC;
    localparam int W_REF = 9 + LOG2_DEC;
    localparam int FW    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(LAT - 1);
    localparam logic [15:0]   TOL_U      = 16'(TOL);

    state_e                state_q, state_d;
    logic [FW-1:0]         flush_cnt_q, flush_cnt_d;
    logic [LOG2_DEC-1:0]   cnt_q, cnt_d;
    logic [7:0]            dly_q [LAT];
    logic [7:0]            dly_d [LAT];
    logic signed [W_DEC-1:0] dec_out_q, dec_out_d;
    logic signed [W_REF-1:0] ref_out_q, ref_out_d;
    logic                  dec_valid_q, dec_valid_d;
    logic                  err_flag_q, err_flag_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic                  run_act, win_end, win_fail;
    logic signed [4:0]     s_dat;
    logic signed [8:0]     r_dat;
    logic signed [W_DEC-1:0] dec_sum;
    logic signed [W_REF-1:0] ref_sum;
    logic signed [15:0]    dec_ext, ref_ext, diff;
    logic [15:0]           abs_diff;

    // Delay line realigns d_in with the DAC pipeline; it runs regardless of state.
    always_comb begin
        dly_d[0] = d_in;
        for (int i = 1; i < LAT; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    assign s_dat = (el_val(d_el_3) <<< 3) + (el_val(d_el_2) <<< 2)
                 + (el_val(d_el_1) <<< 1) + el_val(d_el_0);
    assign r_dat = $signed({1'b0, dly_q[LAT-1]}) - REF_OFFSET;

    assign run_act = (state_q == ST_RUN) && en;
    assign win_end = run_act && (cnt_q == '1);

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end
            end
            ST_FLUSH: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    ef_smsdac_mon_boxcar #(.W_IN(5), .LOG2_DEC(LOG2_DEC)) u_boxcar_dec (
        .clk    (clk),
        .rst_b  (rst_b),
        .clr    (!run_act),
        .acc_en (run_act),
        .dump   (win_end),
        .din    (s_dat),
        .sum    (dec_sum)
    );

    ef_smsdac_mon_boxcar #(.W_IN(9), .LOG2_DEC(LOG2_DEC)) u_boxcar_ref (
        .clk    (clk),
        .rst_b  (rst_b),
        .clr    (!run_act),
        .acc_en (run_act),
        .dump   (win_end),
        .din    (r_dat),
        .sum    (ref_sum)
    );

    assign dec_ext  = {{(16-W_DEC){dec_sum[W_DEC-1]}}, dec_sum};
    assign ref_ext  = {{(16-W_REF){ref_sum[W_REF-1]}}, ref_sum};
    assign diff     = ref_ext - (dec_ext <<< SHIFT);
    assign abs_diff = diff[15] ? -diff : diff;
    assign win_fail = win_end && (abs_diff > TOL_U);

    // A failing window outranks a same-cycle clear so the failure is never lost.
    always_comb begin
        cnt_d       = run_act ? cnt_q + LOG2_DEC'(1) : '0;
        dec_out_d   = win_end ? dec_sum : dec_out_q;
        ref_out_d   = win_end ? ref_sum : ref_out_q;
        dec_valid_d = win_end;
        err_flag_d  = err_flag_q;
        err_cnt_d   = err_cnt_q;
        if (win_fail) begin
            err_flag_d = 1'b1;
            if (clr) begin
                err_cnt_d = 8'd1;
            end else if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end else if (clr) begin
            err_flag_d = 1'b0;
            err_cnt_d  = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < LAT; i++) begin
                dly_q[i] <= '0;
            end
            dec_out_q   <= '0;
            ref_out_q   <= '0;
            dec_valid_q <= 1'b0;
            err_flag_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            cnt_q       <= cnt_d;
            dly_q       <= dly_d;
            dec_out_q   <= dec_out_d;
            ref_out_q   <= ref_out_d;
            dec_valid_q <= dec_valid_d;
            err_flag_q  <= err_flag_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign dec_out   = dec_out_q;
    assign ref_out   = ref_out_q;
    assign dec_valid = dec_valid_q;
    assign err_flag  = err_flag_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
